data_split: RTL

DATA_SPLIT -- requirements
Module: data_split

---
 rtl/data_split.sv | 66 ++++++
 1 files changed

// File: rtl/data_split.sv
// data_split: splits each 32-bit input word into two 16-bit samples on a valid/ready stream
module data_split #(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] indata,
  input  logic        invalid,
  output logic        inready,
  output logic [15:0] outdata,
  output logic        outvalid,
  input  logic        outready,
  output logic        outhalf,
  output logic        underrun,
  input  logic        underrun_clr
);
  typedef enum logic [1:0] {EMPTY, FIRST, SECOND} state_t;
  state_t      state;
  logic [31:0] word;
  logic        seen;
  logic        in_xfer;
  logic        out_xfer;
  logic [15:0] in_first;
  logic [15:0] word_second;
  assign inready     = (state == EMPTY) | ((state == SECOND) & outready);
  assign in_xfer     = invalid & inready;
  assign out_xfer    = outvalid & outready;
  assign in_first    = LOW_FIRST ? indata[15:0] : indata[31:16];
  assign word_second = LOW_FIRST ? word[31:16] : word[15:0];
  // Word capture, half sequencing and registered sample outputs; a load in SECOND chains straight into FIRST
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= EMPTY;
      word     <= '0;
      outdata  <= '0;
      outvalid <= 1'b0;
      outhalf  <= 1'b0;
    end else if (in_xfer) begin
      state    <= FIRST;
      word     <= indata;
      outdata  <= in_first;
      outvalid <= 1'b1;
      outhalf  <= 1'b0;
    end else if (state == FIRST && out_xfer) begin
      state   <= SECOND;
      outdata <= word_second;
      outhalf <= 1'b1;
    end else if (state == SECOND && out_xfer) begin
      state    <= EMPTY;
      outvalid <= 1'b0;
    end
  end
  // Sticky underrun: sink ready while empty after a word has been seen; clear beats set
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seen     <= 1'b0;
      underrun <= 1'b0;
    end else if (underrun_clr) begin
      seen     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (in_xfer) seen <= 1'b1;
      if (state == EMPTY && outready && seen) underrun <= 1'b1;
    end
  end
endmodule
